// File: rtl/spr_window_gen_l.sv
// Horizontal 3-tap window generator (prev/curr/next) with zero-padded line borders,
// 2-cycle aligned syncs, first/last flags and column/row counters.
module spr_window_gen_l #(
   parameter int DW    = 12,
   parameter int H_MAX = 4095,
   parameter int CW    = 12
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_hs,
   input  logic          i_vs,
   input  logic [DW-1:0] i_pix,
   output logic          o_hs,
   output logic          o_vs,
   output logic [DW-1:0] o_prev,
   output logic [DW-1:0] o_curr,
   output logic [DW-1:0] o_next,
   output logic          o_is_first_pixel,
   output logic          o_is_last_pixel,
   output logic [CW-1:0] o_col,
   output logic [CW-1:0] o_row,
   output logic          o_overflow
);

   // Stream semantics: an output pixel is valid exactly when o_hs & o_vs; there is
   // no ready, the pipeline never stalls and moves one pixel per clock.
   localparam logic [CW-1:0] COL_MAX = CW'(H_MAX - 1);

   logic          act;
   logic          out_act;
   logic          ovf_set;

   logic          hs1_q, vs1_q, act1_q;
   logic [DW-1:0] pix1_q, pix1_d;
   logic          hs2_q, vs2_q;
   logic [DW-1:0] prev_q, prev_d, curr_q, curr_d, next_q, next_d;
   logic          first_q, first_d, last_q, last_d;
   logic [CW-1:0] col_q, col_d, row_q, row_d;
   logic          ovf_q, ovf_d;

   assign act     = i_hs & i_vs;
   assign out_act = hs2_q & vs2_q;
   assign pix1_d  = act ? i_pix : '0;

   always_comb begin
      prev_d  = '0;
      curr_d  = '0;
      next_d  = '0;
      first_d = 1'b0;
      last_d  = 1'b0;
      col_d   = '0;
      ovf_set = 1'b0;
      if (act1_q) begin
         curr_d  = pix1_q;
         // curr_q is zero unless the previous cycle carried a pixel of this line
         prev_d  = curr_q;
         next_d  = act ? i_pix : '0;
         first_d = ~out_act;
         last_d  = ~act;
         if (!out_act) begin
            col_d = '0;
         end else if (col_q == COL_MAX) begin
            col_d   = col_q;
            ovf_set = 1'b1;
         end else begin
            col_d = col_q + 1'b1;
         end
      end
   end

   always_comb begin
      row_d = row_q;
      ovf_d = ovf_q | ovf_set;
      if (!vs1_q) begin
         row_d = '0;
         ovf_d = 1'b0;
      end else if (hs2_q && !hs1_q && (row_q != '1)) begin
         row_d = row_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hs1_q   <= 1'b0;
         vs1_q   <= 1'b0;
         act1_q  <= 1'b0;
         pix1_q  <= '0;
         hs2_q   <= 1'b0;
         vs2_q   <= 1'b0;
         prev_q  <= '0;
         curr_q  <= '0;
         next_q  <= '0;
         first_q <= 1'b0;
         last_q  <= 1'b0;
         col_q   <= '0;
         row_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         hs1_q   <= i_hs;
         vs1_q   <= i_vs;
         act1_q  <= act;
         pix1_q  <= pix1_d;
         hs2_q   <= hs1_q;
         vs2_q   <= vs1_q;
         prev_q  <= prev_d;
         curr_q  <= curr_d;
         next_q  <= next_d;
         first_q <= first_d;
         last_q  <= last_d;
         col_q   <= col_d;
         row_q   <= row_d;
         ovf_q   <= ovf_d;
      end
   end

   assign o_hs             = hs2_q;
   assign o_vs             = vs2_q;
   assign o_prev           = prev_q;
   assign o_curr           = curr_q;
   assign o_next           = next_q;
   assign o_is_first_pixel = first_q;
   assign o_is_last_pixel  = last_q;
   assign o_col            = col_q;
   assign o_row            = row_q;
   assign o_overflow       = ovf_q;

endmodule
